data_sram_bridge: RTL

//  Multi-cycle data-memory bridge directly downstream of the execute stage. Converts execute's

---
 rtl/data_sram_bridge_pkg.sv | 12 +
 rtl/data_sram_bridge.sv | 111 +++++++++++
 2 files changed

// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: state encoding and bus constants shared by the data SRAM bridge
package data_sram_bridge_pkg;
   typedef enum logic [1:0] {
      DSB_IDLE = 2'd0,
      DSB_REQ  = 2'd1,
      DSB_WAIT = 2'd2,
      DSB_DONE = 2'd3
   } dsb_state_e;
   localparam logic [1:0]  SIZE_WORD = 2'b10;
   localparam logic [3:0]  WSTRB_ALL = 4'b1111;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
endpackage

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns execute's one-cycle memory strobe into a req/addr_ok/data_ok SRAM bus transfer, stalling the core meanwhile
//  clk, resetn                       clock, asynchronous active-low reset
//  mem_cs_i/mem_rw_i/mem_addr_i/     access request from execute (rw: 1 = load, 0 = store)
//  mem_wdata_i
//  mem_rdata_o                       load data, nonzero only in DONE
//  stall_o                           hold the core while a transfer is outstanding
//  adel_o/ades_o                     misaligned load/store, combinational in IDLE
//  bus_err_o                         timeout abort flag, valid in DONE
//  data_sram_*                       SRAM-like bus (req/wr/size/addr/wdata/wstrb, addr_ok/data_ok/rdata)
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_cs_i,
   input  logic        mem_rw_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic        stall_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic        bus_err_o,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   output logic [3:0]  data_sram_wstrb,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata
);
   // a zero-width counter is illegal, so a disabled timeout still gets one bit
   localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   dsb_state_e state, state_nx;
   logic [CW-1:0] cnt;
   logic [31:0] rdata_q;
   logic wr_q, err_q, aligned, start, timeout, finish_ok, stall_int;
   assign aligned = mem_addr_i[1:0] == 2'b00;
   assign start = state == DSB_IDLE && mem_cs_i && aligned;
   assign timeout = TIMEOUT_CYC != 0 && (state == DSB_REQ || state == DSB_WAIT) && cnt == CW'(TIMEOUT_CYC);
   assign finish_ok = (state == DSB_REQ && data_sram_addr_ok && data_sram_data_ok) || (state == DSB_WAIT && data_sram_data_ok);
   assign data_sram_size = SIZE_WORD;
   assign data_sram_wr = wr_q;
   assign data_sram_wstrb = wr_q ? WSTRB_ALL : 4'b0000;
   // the IDLE stall is combinational on mem_cs_i, so reset must mask it explicitly
   assign stall_o = stall_int && resetn;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= DSB_IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      stall_int = 1'b0;
      data_sram_req = 1'b0;
      adel_o = 1'b0;
      ades_o = 1'b0;
      mem_rdata_o = ZERO_WORD;
      bus_err_o = 1'b0;
      case (state)
         DSB_IDLE: begin
            stall_int = start;
            adel_o = mem_cs_i && !aligned && mem_rw_i;
            ades_o = mem_cs_i && !aligned && !mem_rw_i;
            state_nx = start ? DSB_REQ : DSB_IDLE;
         end
         DSB_REQ: begin
            stall_int = 1'b1;
            // withdraw the request on the abort cycle so the bus cannot accept it
            data_sram_req = !timeout;
            state_nx = (timeout || finish_ok) ? DSB_DONE : data_sram_addr_ok ? DSB_WAIT : DSB_REQ;
         end
         DSB_WAIT: begin
            stall_int = 1'b1;
            state_nx = (timeout || data_sram_data_ok) ? DSB_DONE : DSB_WAIT;
         end
         default: begin
            mem_rdata_o = rdata_q;
            bus_err_o = err_q;
            state_nx = DSB_IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_sram_addr <= ZERO_WORD;
         data_sram_wdata <= ZERO_WORD;
         wr_q <= 1'b0;
         rdata_q <= ZERO_WORD;
         err_q <= 1'b0;
         cnt <= '0;
      end else begin
         if (start) begin
            data_sram_addr <= mem_addr_i;
            data_sram_wdata <= mem_wdata_i;
            wr_q <= !mem_rw_i;
            rdata_q <= ZERO_WORD;
            err_q <= 1'b0;
         end
         if (timeout) begin
            err_q <= 1'b1;
            rdata_q <= ZERO_WORD;
         end else if (finish_ok) rdata_q <= wr_q ? ZERO_WORD : data_sram_rdata;
         cnt <= (state == DSB_IDLE) ? '0 :
                ((state == DSB_REQ && !data_sram_addr_ok) || (state == DSB_WAIT && !data_sram_data_ok)) ? cnt + 1'b1 : cnt;
      end
   end
endmodule
